mem_io_responder: RTL and testbench

- Memory/IO-side responder for the CPU's byte-wide external bus (address, write data, write strobe, read data, UART-full flag).
- Serves the 128 KB main RAM and decodes the memory-mapped I/O window: UART tx/rx at 0x30000, cycle counter and program stop at 0x30004.
- Buffers outbound UART bytes in a FIFO and drives io_buffer_full back to the CPU.
- Used as the simulation/FPGA counterpart of the CPU core.

---
 rtl/mem_io_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory/IO-side responder for the CPU's byte-wide bus.
// Serves the main RAM and decodes the I/O window at 0x30000:
//   0x30000 write : push a nonzero byte into the UART tx FIFO
//   0x30000 read  : take a byte from the UART rx side (0x00 if none waiting)
//   0x30004 write : stop the program (halted), and push a 0x00 marker byte
//   0x30004..7 rd : snapshot of the free-running cycle counter, byte by byte
// Optional build macro: MEM_IO_BOUNDS_CHECK_EN adds a sticky bus_err output
// that flags accesses outside RAM / the legal IO registers.
module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
`ifdef MEM_IO_BOUNDS_CHECK_EN
    output logic        bus_err,
`endif
    output logic        halted
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TX_DEPTH);
    localparam logic [PTR_W:0] NEAR_CNT = (PTR_W+1)'(TX_DEPTH - FULL_MARGIN);

    // Storage
    logic [7:0] ram [0:(1<<RAM_AW)-1];
    logic [7:0] tx_mem [0:TX_DEPTH-1];

    // FIFO state
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;

    // Cycle counter and the upper bytes captured when byte 0 is read
    logic [31:0] cycle_count;
    logic [31:8] cnt_latch;

    // Low while reset is held and on the first edge after release, so a
    // RAM write that is in flight when reset asserts never lands
    logic active;

    // Decode
    logic              is_io;
    logic [2:0]        io_off;
    logic [RAM_AW-1:0] ram_addr;
    logic              access_fault;
    logic              ram_we;
    logic              io_wr;
    logic              push_req;
    logic [7:0]        push_data;
    logic              push;
    logic              pop;

    assign is_io    = (mem_a[17:16] == 2'b11);
    assign io_off   = mem_a[2:0];
    assign ram_addr = mem_a[RAM_AW-1:0];

`ifdef MEM_IO_BOUNDS_CHECK_EN
    assign access_fault = (mem_a[17:16] == 2'b10) || (mem_a[31:18] != '0) ||
                          (is_io && mem_wr && (mem_a[15:0] != 16'h0000) &&
                           (mem_a[15:0] != 16'h0004));
`else
    // Without bounds checking the high address bits simply alias away
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_a[31:18];
    assign access_fault = 1'b0;
`endif

    assign ram_we = mem_wr && !is_io && !access_fault && active;
    assign io_wr  = mem_wr && is_io && !access_fault;

    // Nonzero bytes at 0x30000 and the halt marker at 0x30004 go to the FIFO
    assign push_req  = io_wr && (((io_off == 3'd0) && (mem_dout != 8'h00)) ||
                                 (io_off == 3'd4));
    assign push_data = (io_off == 3'd4) ? 8'h00 : mem_dout;

    // A pop in the same cycle frees the slot, so a push to a full FIFO succeeds
    assign tx_valid       = (fifo_count != '0);
    assign tx_data        = tx_mem[rd_ptr];
    assign pop            = tx_valid && tx_ready;
    assign push           = push_req && ((fifo_count != FULL_CNT) || pop);
    assign io_buffer_full = (fifo_count >= NEAR_CNT);

    // Track whether we are out of reset for at least one edge
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    // FIFO storage; the pointers alone decide what is valid
    always_ff @(posedge clk_in) begin
        if (push) begin
            tx_mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Free-running cycle counter, wraps naturally at 32 bits
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Registered read data, rx handshake and counter snapshot
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din   <= 8'h00;
            rx_ready  <= 1'b0;
            cnt_latch <= '0;
        end else begin
            rx_ready <= 1'b0;
            if (!mem_wr) begin
                if (access_fault) begin
                    mem_din <= 8'h00;
                end else if (is_io) begin
                    case (io_off)
                        3'd0: begin
                            mem_din  <= rx_valid ? rx_data : 8'h00;
                            rx_ready <= rx_valid;
                        end
                        3'd4: begin
                            mem_din   <= cycle_count[7:0];
                            cnt_latch <= cycle_count[31:8];
                        end
                        3'd5:    mem_din <= cnt_latch[15:8];
                        3'd6:    mem_din <= cnt_latch[23:16];
                        3'd7:    mem_din <= cnt_latch[31:24];
                        default: mem_din <= 8'h00;
                    endcase
                end else begin
                    mem_din <= ram[ram_addr];
                end
            end
        end
    end

    // Sticky program-stop flag
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            halted <= 1'b0;
        end else if (io_wr && (io_off == 3'd4)) begin
            halted <= 1'b1;
        end
    end

`ifdef MEM_IO_BOUNDS_CHECK_EN
    // Sticky record of any out-of-range or illegal IO access
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bus_err <= 1'b0;
        end else if (access_fault) begin
            bus_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed checks of RAM access, tx FIFO fill/drain,
// halt marker, rx handshake, counter snapshot, and reset of the FIFO.
module tb_mem_io_responder;

    localparam logic [31:0] IDLE_ADDR = 32'h0000_0123;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halted;
`ifdef MEM_IO_BOUNDS_CHECK_EN
    logic        bus_err;
`endif

    int num_checks = 0;
    int num_fails  = 0;

    logic [7:0] drain_exp [8];

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
`ifdef MEM_IO_BOUNDS_CHECK_EN
        .bus_err        (bus_err),
`endif
        .halted         (halted)
    );

    // 10-unit clock
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Present one bus access for a single edge, then return the bus to idle
    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] data,
                                 input logic wr);
        mem_a    = addr;
        mem_dout = data;
        mem_wr   = wr;
        stepCycle();
        mem_a    = IDLE_ADDR;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
    endtask

    initial begin
        rst_in   = 1'b0;
        mem_a    = IDLE_ADDR;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        drain_exp = '{8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h5A};

        // Reset state
        @(negedge clk_in);
        @(negedge clk_in);
        checkOutput("rst_mem_din", 32'(mem_din), 32'h00);
        checkOutput("rst_halted", 32'(halted), 32'h0);
        checkOutput("rst_rx_ready", 32'(rx_ready), 32'h0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("rst_full", 32'(io_buffer_full), 32'h0);
        rst_in = 1'b1;
        stepCycle();

        // RAM write then read-back
        applyStimulus(32'h0000_0123, 8'hA5, 1'b1);
        applyStimulus(32'h0000_0123, 8'h00, 1'b0);
        checkOutput("ram_rd_123", 32'(mem_din), 32'hA5);
        applyStimulus(32'h0001_FFFF, 8'h3C, 1'b1);
        applyStimulus(32'h0001_FFFF, 8'h00, 1'b0);
        checkOutput("ram_rd_1ffff", 32'(mem_din), 32'h3C);
        applyStimulus(32'h0000_0123, 8'h00, 1'b0);
        checkOutput("ram_rd_123_again", 32'(mem_din), 32'hA5);

        // Fill the tx FIFO with the sink stalled
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h0003_0000, 8'h41 + 8'(i), 1'b1);
            checkOutput($sformatf("full_after_%0d", i + 1), 32'(io_buffer_full),
                        (i >= 5) ? 32'h1 : 32'h0);
        end
        applyStimulus(32'h0003_0000, 8'h49, 1'b1);
        checkOutput("fill_head", 32'(tx_data), 32'h41);
        checkOutput("fill_valid", 32'(tx_valid), 32'h1);

        // Drain: bytes in order, the dropped 0x49 never appears
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("drain_valid_%0d", k), 32'(tx_valid), 32'h1);
            checkOutput($sformatf("drain_data_%0d", k), 32'(tx_data), 32'h41 + k);
            stepCycle();
        end
        checkOutput("drain_empty", 32'(tx_valid), 32'h0);
        checkOutput("drain_not_full", 32'(io_buffer_full), 32'h0);
        tx_ready = 1'b0;

        // Null byte is ignored; halt write pushes a 0x00 marker
        applyStimulus(32'h0003_0000, 8'h00, 1'b1);
        checkOutput("null_no_push", 32'(tx_valid), 32'h0);
        checkOutput("null_not_halted", 32'(halted), 32'h0);
        applyStimulus(32'h0003_0004, 8'h01, 1'b1);
        checkOutput("halt_set", 32'(halted), 32'h1);
        checkOutput("halt_push_valid", 32'(tx_valid), 32'h1);
        checkOutput("halt_push_data", 32'(tx_data), 32'h00);
        tx_ready = 1'b1;
        stepCycle();
        tx_ready = 1'b0;
        checkOutput("halt_drained", 32'(tx_valid), 32'h0);

        // RX reads
        applyStimulus(32'h0003_0000, 8'h00, 1'b0);
        checkOutput("rx_idle_data", 32'(mem_din), 32'h00);
        checkOutput("rx_idle_ready", 32'(rx_ready), 32'h0);
        rx_valid = 1'b1;
        rx_data  = 8'h7E;
        applyStimulus(32'h0003_0000, 8'h00, 1'b0);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        checkOutput("rx_data", 32'(mem_din), 32'h7E);
        checkOutput("rx_ready_pulse", 32'(rx_ready), 32'h1);
        stepCycle();
        checkOutput("rx_ready_single", 32'(rx_ready), 32'h0);

        // Counter snapshot from a preloaded value
        force dut.cycle_count = 32'h0102_FFFF;
        mem_a  = 32'h0003_0004;
        mem_wr = 1'b0;
        @(posedge clk_in);
        #1;
        release dut.cycle_count;
        @(negedge clk_in);
        mem_a = IDLE_ADDR;
        checkOutput("cnt_byte0", 32'(mem_din), 32'hFF);
        applyStimulus(32'h0003_0005, 8'h00, 1'b0);
        checkOutput("cnt_byte1", 32'(mem_din), 32'hFF);
        applyStimulus(32'h0003_0006, 8'h00, 1'b0);
        checkOutput("cnt_byte2", 32'(mem_din), 32'h02);
        applyStimulus(32'h0003_0007, 8'h00, 1'b0);
        checkOutput("cnt_byte3", 32'(mem_din), 32'h01);

        // Full FIFO with a simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h0003_0000, 8'h51 + 8'(i), 1'b1);
        end
        checkOutput("full2_flag", 32'(io_buffer_full), 32'h1);
        tx_ready = 1'b1;
        applyStimulus(32'h0003_0000, 8'h5A, 1'b1);
        checkOutput("pushpop_full", 32'(io_buffer_full), 32'h1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("pp_valid_%0d", k), 32'(tx_valid), 32'h1);
            checkOutput($sformatf("pp_data_%0d", k), 32'(tx_data), 32'(drain_exp[k]));
            stepCycle();
        end
        checkOutput("pp_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Asynchronous reset in the middle of a write
        applyStimulus(32'h0003_0000, 8'h61, 1'b1);
        applyStimulus(32'h0003_0000, 8'h62, 1'b1);
        checkOutput("pre_rst_valid", 32'(tx_valid), 32'h1);
        mem_a    = 32'h0003_0000;
        mem_dout = 8'h63;
        mem_wr   = 1'b1;
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(tx_valid), 32'h0);
        checkOutput("async_rst_full", 32'(io_buffer_full), 32'h0);
        checkOutput("async_rst_halted", 32'(halted), 32'h0);
        checkOutput("async_rst_mem_din", 32'(mem_din), 32'h00);
        @(negedge clk_in);
        mem_a    = IDLE_ADDR;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        rst_in   = 1'b1;
        stepCycle();
        checkOutput("post_rst_valid", 32'(tx_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_fails);
        $finish;
    end

endmodule
